// File: rtl/dsp_pkg.sv
// Shared DSP types: instruction word layout, the NOP encoding and the sequencer state encoding.
// Used by dsp_sequencer, its program RAM and dsp_core.
package dsp_pkg;

  typedef logic [5:0] opcode_t;

  // 26-bit instruction word: opcode, sample-RAM address, parameter-RAM address.
  typedef struct packed {
    opcode_t    opcode;
    logic [9:0] sample_addr;
    logic [9:0] param_addr;
  } instr_t;

  localparam instr_t InstrNop = '0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } seq_state_t;

endpackage

// File: rtl/dsp_instr_ram.sv
// Program RAM for dsp_sequencer. Simple dual-port memory with one write port and one registered
// read port. When a read and a write hit the same address in the same cycle, the read returns the
// old contents. Contents are not reset.
// Ports:
//   clk        clock
//   wr_en_i    write strobe; wr_addr_i / wr_data_i select the word and its new value
//   rd_en_i    read strobe; rd_addr_i selects the word
//   rd_data_o  registered read data, held while rd_en_i is low
module dsp_instr_ram #(
  parameter int unsigned Width     = 26,
  parameter int unsigned AddrWidth = 10
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [Width-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [Width-1:0]     rd_data_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  // The read samples mem_q before this edge's write lands, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dsp_sequencer.sv
// Per-frame instruction sequencer for one dsp_core. On an accepted frame_start_i it issues prog_len
// instructions from the program RAM back-to-back, issues NOPs while the core pipeline drains, then
// pulses frame_done_o. A frame_start_i that arrives while busy is ignored and sets overrun_o.
// Optional build macro DSP_SEQ_PROG_SWAP_EN: the RAM holds two banks. The host writes the inactive
// bank, and a requested swap is applied on the next accepted frame start.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   frame_start_i          1-cycle strobe, new sample frame
//   prog_len_i             instructions per frame, latched on frame accept, saturates at 2**PcWidth
//   prog_wr_en_i/addr/data host program write port
//   instruction_o          instruction to dsp_core, NOP when not issuing
//   busy_o                 frame in progress
//   frame_done_o           1-cycle pulse once the last writeback has completed
//   overrun_o / overrun_clr_i  sticky overrun flag and its clear (setting wins)
//   bank_swap_req_i, active_bank_o  (DSP_SEQ_PROG_SWAP_EN only) swap request and fetch bank
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned InstrWidth = 26,
  parameter int unsigned PcWidth    = 10,
  parameter int unsigned PipeDepth  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start_i,
  input  logic [PcWidth:0]      prog_len_i,
  input  logic                  prog_wr_en_i,
  input  logic [PcWidth-1:0]    prog_wr_addr_i,
  input  logic [InstrWidth-1:0] prog_wr_data_i,
`ifdef DSP_SEQ_PROG_SWAP_EN
  input  logic                  bank_swap_req_i,
  output logic                  active_bank_o,
`endif
  output logic [InstrWidth-1:0] instruction_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i
);

`ifdef DSP_SEQ_PROG_SWAP_EN
  localparam int unsigned AddrWidth = PcWidth + 1;
`else
  localparam int unsigned AddrWidth = PcWidth;
`endif
  localparam int unsigned   CntWidth = $clog2(PipeDepth + 2);
  localparam logic [PcWidth:0] MaxLen = {1'b1, {PcWidth{1'b0}}};

  seq_state_t            state_q, state_d;
  logic [PcWidth-1:0]    pc_q, pc_d;
  logic [PcWidth:0]      len_q, len_d, len_sat;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  issue_valid_q, frame_done_q, frame_done_d, overrun_q, overrun_d;
  logic                  fetch_en, accept;
  logic [AddrWidth-1:0]  rd_addr, wr_addr;
  logic [InstrWidth-1:0] ram_rdata;

  assign len_sat = (prog_len_i > MaxLen) ? MaxLen : prog_len_i;
  assign busy_o  = (state_q != StIdle);
  assign accept  = (state_q == StIdle) && frame_start_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    fetch_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          pc_d    = '0;
          len_d   = len_sat;
          cnt_d   = '0;
          state_d = (len_sat == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        fetch_en = 1'b1;
        pc_d     = pc_q + 1'b1;
        if ({1'b0, pc_q} == len_q - 1'b1) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        // PipeDepth+1 cycles: the last instruction's issue slot plus every core stage after it.
        if (cnt_q == CntWidth'(PipeDepth)) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (frame_start_i && busy_o) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      issue_valid_q <= fetch_en;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef DSP_SEQ_PROG_SWAP_EN
  logic active_bank_q, active_bank_d, pending_q, pending_d, swap_now;

  // A request in the same cycle as the accepting frame_start_i is honoured immediately.
  assign swap_now      = accept && (pending_q || bank_swap_req_i);
  assign active_bank_d = active_bank_q ^ swap_now;
  assign pending_d     = swap_now ? 1'b0 : (pending_q || bank_swap_req_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_bank_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      active_bank_q <= active_bank_d;
      pending_q     <= pending_d;
    end
  end

  assign active_bank_o = active_bank_q;
  assign rd_addr       = {active_bank_q, pc_q};
  assign wr_addr       = {~active_bank_q, prog_wr_addr_i};
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign rd_addr       = pc_q;
  assign wr_addr       = prog_wr_addr_i;
`endif

  dsp_instr_ram #(
    .Width     (InstrWidth),
    .AddrWidth (AddrWidth)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (prog_wr_en_i),
    .wr_addr_i (wr_addr),
    .wr_data_i (prog_wr_data_i),
    .rd_en_i   (fetch_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rdata)
  );

  // Gating on a reset-cleared register forces a NOP as soon as reset asserts.
  assign instruction_o = issue_valid_q ? ram_rdata : InstrWidth'(InstrNop);
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Scoreboard bench for dsp_sequencer. The driver feeds one set of inputs per clock into a
// frame-level reference model, which pushes the expected post-edge outputs into a queue. A
// separate monitor pops one entry per clock and compares it against the DUT.
module tb_dsp_sequencer;

  localparam int unsigned IW = 26;
  localparam int unsigned PW = 10;
  localparam int unsigned PD = 4;
  localparam int DEPTH = 1 << PW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [PW:0]   prog_len = '0;
  logic          prog_wr_en = 1'b0;
  logic [PW-1:0] prog_wr_addr = '0;
  logic [IW-1:0] prog_wr_data = '0;
  logic          overrun_clr = 1'b0;
  logic [IW-1:0] instruction;
  logic          busy, frame_done, overrun;
`ifdef DSP_SEQ_PROG_SWAP_EN
  logic          bank_swap_req = 1'b0;
  logic          active_bank;
`endif

  always #5 clk = ~clk;

  dsp_sequencer #(
    .InstrWidth (IW),
    .PcWidth    (PW),
    .PipeDepth  (PD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start_i  (frame_start),
    .prog_len_i     (prog_len),
    .prog_wr_en_i   (prog_wr_en),
    .prog_wr_addr_i (prog_wr_addr),
    .prog_wr_data_i (prog_wr_data),
`ifdef DSP_SEQ_PROG_SWAP_EN
    .bank_swap_req_i(bank_swap_req),
    .active_bank_o  (active_bank),
`endif
    .instruction_o  (instruction),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .overrun_o      (overrun),
    .overrun_clr_i  (overrun_clr)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          busy;
    logic          done;
    logic          ovr;
`ifdef DSP_SEQ_PROG_SWAP_EN
    logic          bank;
`endif
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: a frame is described by its accept cycle, length and end cycle.
  logic [IW-1:0] m_mem [2][DEPTH];
  bit m_active = 1'b0;
  bit m_ovr = 1'b0;
  bit m_bank = 1'b0;
  bit m_pend = 1'b0;
  int m_k = 0;
  int m_len = 0;
  int m_end = 0;
  int m_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_step(bit fs, logic [PW:0] len, bit we, logic [PW-1:0] wa,
                                     logic [IW-1:0] wd, bit clr, bit swap);
    exp_t e;
    bit   busy_before, acc, wbank;
    e = '0;
    busy_before = m_active && (m_cyc <= m_end);
    if (m_active && m_cyc > m_k && m_cyc <= m_k + m_len) e.instr = m_mem[m_bank][m_cyc - m_k - 1];
    e.done = m_active && (m_cyc == m_end);
`ifdef DSP_SEQ_PROG_SWAP_EN
    wbank = ~m_bank;
`else
    wbank = 1'b0;
`endif
    acc = fs && !busy_before;
    if (acc) begin
      m_active = 1'b1;
      m_k      = m_cyc;
      m_len    = (int'(len) > DEPTH) ? DEPTH : int'(len);
      m_end    = m_k + m_len + PD + 1;
    end
    if (acc && (m_pend || swap)) begin
`ifdef DSP_SEQ_PROG_SWAP_EN
      m_bank = ~m_bank;
`endif
      m_pend = 1'b0;
    end else if (swap) begin
      m_pend = 1'b1;
    end
    e.busy = m_active && (m_cyc >= m_k) && (m_cyc < m_end);
    if (fs && busy_before) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    e.ovr = m_ovr;
`ifdef DSP_SEQ_PROG_SWAP_EN
    e.bank = m_bank;
`endif
    if (we) m_mem[wbank][wa] = wd;
    exp_q.push_back(e);
    m_cyc++;
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_ovr    = 1'b0;
    m_bank   = 1'b0;
    m_pend   = 1'b0;
    exp_q.delete();
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("instruction", 64'(instruction), 64'(mon_e.instr));
      check("busy", 64'(busy), 64'(mon_e.busy));
      check("frame_done", 64'(frame_done), 64'(mon_e.done));
      check("overrun", 64'(overrun), 64'(mon_e.ovr));
`ifdef DSP_SEQ_PROG_SWAP_EN
      check("active_bank", 64'(active_bank), 64'(mon_e.bank));
`endif
    end
  end

  // Drive one clock's inputs (called at a negedge) and record the expected response.
  task automatic drive(bit fs, int len, bit we, int wa, logic [IW-1:0] wd, bit clr, bit swap);
    frame_start  = fs;
    prog_len     = len[PW:0];
    prog_wr_en   = we;
    prog_wr_addr = wa[PW-1:0];
    prog_wr_data = wd;
    overrun_clr  = clr;
`ifdef DSP_SEQ_PROG_SWAP_EN
    bank_swap_req = swap;
`endif
    model_step(fs, len[PW:0], we, wa[PW-1:0], wd, clr, swap);
  endtask

  task automatic tick(bit fs, int len, bit we, int wa, logic [IW-1:0] wd, bit clr, bit swap);
    drive(fs, len, we, wa, wd, clr, swap);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic start(int len);
    tick(1'b1, len, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(int a, logic [IW-1:0] d);
    tick(1'b0, 0, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic clear_ovr();
    tick(1'b0, 0, 1'b0, 0, '0, 1'b1, 1'b0);
  endtask

  // Runs until the frame_done edge of the latest accepted frame has been checked.
  task automatic run_out();
    while (m_active && m_cyc <= m_end) idle();
  endtask

  task automatic commit();
`ifdef DSP_SEQ_PROG_SWAP_EN
    tick(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1);
    start(0);
    run_out();
`endif
  endtask

  task automatic preload();
    for (int a = 0; a < DEPTH; a++) wr(a, IW'($urandom));
  endtask

  task automatic rand_tick(int fs_odds);
    bit fs, we, clr, swap;
    int len;
    fs   = ($urandom_range(0, fs_odds) == 0);
    len  = $urandom_range(0, 12);
    we   = ($urandom_range(0, 3) == 0);
    clr  = ($urandom_range(0, 7) == 0);
    swap = ($urandom_range(0, 15) == 0);
    tick(fs, len, we, $urandom_range(0, 15), IW'($urandom), clr, swap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion",
             checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_instruction", 64'(instruction), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
`ifdef DSP_SEQ_PROG_SWAP_EN
    check("reset_active_bank", 64'(active_bank), 64'd0);
`endif
    reset_n = 1'b1;

    // Fill every word the bench can fetch, in both banks when they exist.
    preload();
    commit();
`ifdef DSP_SEQ_PROG_SWAP_EN
    preload();
`endif

    // Three-instruction frame; a second frame_start at edge k+4 is an overrun.
    wr(0, 26'h0A0_1234);
    wr(1, 26'h0B0_5678);
    wr(2, 26'h0C0_9ABC);
    commit();
    start(3);
    repeat (3) idle();
    start(3);
    run_out();
    clear_ovr();
    idle();

    // frame_start in the last DRAIN cycle is still an overrun.
    start(2);
    while (m_cyc < m_end) idle();
    start(2);
    run_out();
    clear_ovr();

    // Set wins over clear in the same cycle.
    start(3);
    tick(1'b1, 3, 1'b0, 0, '0, 1'b1, 1'b0);
    run_out();
    clear_ovr();

    // Empty program.
    start(0);
    run_out();
    idle();

    // Write collides with the fetch of address 1: old word issued now, new word next frame.
    start(3);
    idle();
    wr(1, 26'h3FF_0001);
    run_out();
    start(3);
    run_out();

    // Reset mid-frame, with the second instruction on the port.
    start(3);
    idle();
    drive(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_instruction", 64'(instruction), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    start(3);
    run_out();

    // Over-long prog_len saturates to the full program depth.
    start(2047);
    run_out();

`ifdef DSP_SEQ_PROG_SWAP_EN
    // Swap requested mid-frame applies only at the next accepted frame.
    for (int a = 0; a < 5; a++) wr(a, IW'($urandom));
    start(5);
    idle();
    tick(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1);
    run_out();
    start(5);
    run_out();
`endif

    // Random traffic: frames, overruns, clears, swaps and writes into the running program.
    repeat (400) rand_tick(6);
    run_out();
    repeat (2) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
